// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC plus loadable instruction memory; fetches one word per READ_LATENCY+1 cycles with stall/jump/branch.
module instr_fetch_unit #(
  parameter int INS_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int READ_LATENCY = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          jump,
  input  logic                          branch,
  input  logic [7:0]                    offset,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [INS_WIDTH-1:0]          load_data,
  output logic [PC_WIDTH-1:0]           pc,
  output logic [INS_WIDTH-1:0]          instruction,
  output logic                          ins_valid,
  output logic                          busy
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  typedef enum logic {WAIT, VALID} state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [INS_WIDTH-1:0] mem [IMEM_DEPTH];
  logic fetch_done;
  logic [PC_WIDTH-1:0] step;
  assign fetch_done = cnt == CW'(READ_LATENCY - 1);
  assign step = (jump | branch) ? PC_WIDTH'(4) + {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00} : PC_WIDTH'(4);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= WAIT;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (state == WAIT) next_state = fetch_done ? VALID : WAIT;
    else next_state = stall ? VALID : WAIT;
  end
  always_comb begin
    busy = state == WAIT;
    ins_valid = state == VALID;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= PC_WIDTH'(RESET_PC);
      cnt <= '0;
      instruction <= '0;
    end else if (state == WAIT) begin
      cnt <= fetch_done ? '0 : cnt + CW'(1);
      if (fetch_done) instruction <= mem[pc[AW+1:2]];
    end else if (!stall) pc <= pc + step;
  // Non-blocking read and write on the same edge give read-before-write.
  always_ff @(posedge clk)
    if (load_en && reset) mem[load_addr] <= load_data;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch timing, redirection, stall, async reset, wrap and load collisions.
module tb_instr_fetch_unit;
  logic clk = 0, reset = 0, stall = 0, jump = 0, branch = 0, load_en = 0;
  logic [7:0] offset = 0, load_addr = 0;
  logic [31:0] load_data = 0, pc, instruction;
  logic ins_valid, busy;
  int total = 0, bad = 0;
  logic [31:0] words [4] = '{32'hFF030201, 32'h00000005, 32'h01020304, 32'h0A0B0C0D};
  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .branch(branch), .offset(offset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .pc(pc), .instruction(instruction), .ins_valid(ins_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en = 1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 0;
  endtask
  initial begin
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_ins", instruction, 0);
    chk("rst_valid", ins_valid, 0);
    chk("rst_busy", busy, 1);
    reset = 1;
    stall = 1;
    for (int i = 0; i < 4; i++) load(8'(i), words[i]);
    load(8'd128, 32'h80808080);
    load(8'd255, 32'h12345678);
    reset = 0;
    #1;
    reset = 1;
    stall = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (k == 0 ? 1 : 2) begin
        tick();
        chk("t1_wait", {busy, ins_valid}, 2'b10);
      end
      tick();
      chk("t1_valid", {busy, ins_valid}, 2'b01);
      chk("t1_pc", pc, 32'(k * 4));
      chk("t1_ins", instruction, words[k]);
    end
    jump = 1;
    offset = 8'hFD;
    tick();
    jump = 0;
    chk("jump_pc", pc, 0);
    tick();
    tick();
    chk("jump_ins", instruction, 32'hFF030201);
    repeat (3) tick();
    chk("pre_stall_pc", pc, 4);
    stall = 1;
    jump = 1;
    repeat (5) begin
      tick();
      chk("stall_valid", ins_valid, 1);
      chk("stall_ins", instruction, 32'h00000005);
      chk("stall_pc", pc, 4);
    end
    stall = 0;
    jump = 0;
    tick();
    chk("unstall_pc", pc, 8);
    tick();
    tick();
    chk("pc8_ins", instruction, 32'h01020304);
    branch = 1;
    offset = 8'h02;
    tick();
    branch = 0;
    chk("branch_pc", pc, 20);
    tick();
    tick();
    jump = 1;
    offset = 8'hFD;
    tick();
    jump = 0;
    chk("back_pc", pc, 12);
    tick();
    reset = 0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_ins", instruction, 0);
    chk("arst_flags", {busy, ins_valid}, 2'b10);
    #1;
    reset = 1;
    tick();
    tick();
    chk("post_rst_valid", ins_valid, 1);
    chk("post_rst_ins", instruction, 32'hFF030201);
    jump = 1;
    offset = 8'h7F;
    tick();
    jump = 0;
    chk("j200_pc", pc, 32'h200);
    tick();
    tick();
    chk("j200_ins", instruction, 32'h80808080);
    jump = 1;
    offset = 8'h7E;
    tick();
    jump = 0;
    chk("j3fc_pc", pc, 32'h3FC);
    tick();
    tick();
    chk("w255_ins", instruction, 32'h12345678);
    tick();
    chk("wrap_pc", pc, 32'h400);
    tick();
    tick();
    chk("wrap_ins", instruction, 32'hFF030201);
    tick();
    tick();
    chk("rbw_pc", pc, 32'h404);
    load(8'd1, 32'hDEADBEEF);
    chk("rbw_valid", ins_valid, 1);
    chk("rbw_ins", instruction, 32'h00000005);
    jump = 1;
    offset = 8'hFF;
    tick();
    jump = 0;
    chk("refetch_pc", pc, 32'h404);
    tick();
    tick();
    chk("refetch_ins", instruction, 32'hDEADBEEF);
    stall = 1;
    load(8'd1, 32'h11111111);
    chk("held_ins", instruction, 32'hDEADBEEF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
